// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory line-port arbiter.
// Requester 0 is the instruction cache, requester 1 the data cache.
package cache_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant from the request pair and
// the previous winner, with the winner pointer registered when grant_en is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       any_req,
  output logic       grant
);

  logic last_grant;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_req = |req;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= 1'b1;
    else if (grant_en) last_grant <= grant;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the cache-to-memory line port between the I-cache (c0) and D-cache (c1)
// with round-robin arbitration, a registered memory request and a response watchdog.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              r,
  input  logic              c0_valid,
  input  logic              c0_rw,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LINE_W-1:0] c0_wdata,
  output logic [LINE_W-1:0] c0_rdata,
  output logic              c0_ready,
  input  logic              c1_valid,
  input  logic              c1_rw,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LINE_W-1:0] c1_wdata,
  output logic [LINE_W-1:0] c1_rdata,
  output logic              c1_ready,
  output logic              arb2mem_valid,
  output logic              arb2mem_rw,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [LINE_W-1:0] arb2mem_data,
  input  logic [LINE_W-1:0] mem2arb_data,
  input  logic              mem2arb_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises cX_valid with stable fields and holds them until
  // its one-cycle cX_ready pulse, dropping valid in that same cycle. Memory sees a
  // request held on arb2mem_* while arb2mem_valid is high and completes it with a
  // single-cycle mem2arb_ready.

  state_e           state_q, state_d;
  logic             any_req, arb_grant, grant_en, mem_done, wd_fire, grant_q;
  logic [CNT_W-1:0] wd_q;

  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (r),
    .req      ({c1_valid, c0_valid}),
    .grant_en (grant_en),
    .any_req  (any_req),
    .grant    (arb_grant)
  );

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge r) begin
    if (!r) state_q <= IDLE;
    else    state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    mem_done = 1'b0;
    wd_fire  = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        grant_en = 1'b1;
        state_d  = BUSY;
      end
      BUSY: if (mem2arb_ready) begin
        mem_done = 1'b1;
        state_d  = RESP;
      end else if ((TIMEOUT != 0) && (wd_q == CNT_W'(TIMEOUT))) begin
        wd_fire = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog holds the number of BUSY cycles spent so far, including the current one.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      grant_q       <= 1'b0;
      wd_q          <= '0;
      arb2mem_valid <= 1'b0;
      arb2mem_rw    <= 1'b0;
      arb2mem_addr  <= '0;
      arb2mem_data  <= '0;
      c0_rdata      <= '0;
      c1_rdata      <= '0;
      c0_ready      <= 1'b0;
      c1_ready      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      c0_ready <= 1'b0;
      c1_ready <= 1'b0;
      if (grant_en) begin
        grant_q       <= arb_grant;
        wd_q          <= CNT_W'(1);
        arb2mem_valid <= 1'b1;
        arb2mem_rw    <= (arb_grant == REQ_D) ? c1_rw    : c0_rw;
        arb2mem_addr  <= (arb_grant == REQ_D) ? c1_addr  : c0_addr;
        arb2mem_data  <= (arb_grant == REQ_D) ? c1_wdata : c0_wdata;
      end else if (mem_done || wd_fire) begin
        arb2mem_valid <= 1'b0;
        if (wd_fire) timeout_err <= 1'b1;
        if (grant_q == REQ_D) begin
          c1_ready <= 1'b1;
          if (wd_fire)          c1_rdata <= '0;
          else if (!arb2mem_rw) c1_rdata <= mem2arb_data;
        end else begin
          c0_ready <= 1'b1;
          if (wd_fire)          c0_rdata <= '0;
          else if (!arb2mem_rw) c0_rdata <= mem2arb_data;
        end
      end else if (state_q == BUSY) begin
        wd_q <= wd_q + CNT_W'(1);
      end else if (state_q == RESP) begin
        wd_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reads, ties, fairness, writes,
// watchdog timeout and asynchronous reset in the middle of a transaction.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          r;
  logic          c0_valid, c0_rw, c1_valid, c1_rw;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [LW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
  logic          c0_ready, c1_ready;
  logic          arb2mem_valid, arb2mem_rw;
  logic [AW-1:0] arb2mem_addr;
  logic [LW-1:0] arb2mem_data, mem2arb_data;
  logic          mem2arb_ready, busy, timeout_err;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  int both_rdy_cnt = 0;
  int rdy_cnt = 0;
  logic [LW-1:0] exp_c1;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .r(r),
    .c0_valid(c0_valid), .c0_rw(c0_rw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ready(c0_ready),
    .c1_valid(c1_valid), .c1_rw(c1_rw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ready(c1_ready),
    .arb2mem_valid(arb2mem_valid), .arb2mem_rw(arb2mem_rw),
    .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
    .mem2arb_data(mem2arb_data), .mem2arb_ready(mem2arb_ready),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (c0_ready && c1_ready) both_rdy_cnt++;
    if (c0_ready || c1_ready) rdy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "bench time limit");
  end

  // Driver tasks
  task automatic apply_reset();
    r = 1'b0;
    repeat (2) @(negedge clk);
    r = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      if (arb2mem_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Returns at the negedge of the cycle in which the ready pulse should be visible.
  task automatic mem_reply(input int delay, input logic [LW-1:0] d);
    repeat (delay) @(negedge clk);
    mem2arb_data  = d;
    mem2arb_ready = 1'b1;
    @(negedge clk);
    mem2arb_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    total++;
    if ({c0_rdata, c1_rdata, c0_ready, c1_ready, arb2mem_valid, arb2mem_rw,
         arb2mem_addr, arb2mem_data, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero want all zero");
    end
    total++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b st=%0d want busy=0 st=0", busy, state_dbg);
    end
  endtask

  task automatic test_single_read();
    bit ok; int n;
    logic [LW-1:0] line = 128'hDEADBEEF_00000000_00000000_00000001;
    c0_rw = 1'b0; c0_addr = 32'h0000_0000; c0_valid = 1'b1;
    wait_req(ok, n);
    total++;
    if (!ok || n != 1) begin
      bad++;
      $display("FAIL read_latency: got ok=%0d n=%0d want ok=1 n=1", ok, n);
    end
    total++;
    if (arb2mem_addr !== 32'h0 || arb2mem_rw !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL read_req: got addr=%h rw=%b busy=%b want 0/0/1", arb2mem_addr, arb2mem_rw, busy);
    end
    mem_reply(2, line);
    total++;
    if (c0_ready !== 1'b1 || c1_ready !== 1'b0 || c0_rdata !== line) begin
      bad++;
      $display("FAIL read_resp: got rdy=%b/%b data=%h want 1/0 %h", c0_ready, c1_ready, c0_rdata, line);
    end
    c0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (c0_ready !== 1'b0 || busy !== 1'b0 || c0_rdata !== line) begin
      bad++;
      $display("FAIL read_pulse: got rdy=%b busy=%b data=%h want 0 0 %h", c0_ready, busy, c0_rdata, line);
    end
  endtask

  task automatic test_simultaneous();
    bit ok; int n;
    logic [LW-1:0] lb = 128'hB0B0B0B0_00000000_00000000_00004010;
    logic [LW-1:0] lc = 128'hC0C0C0C0_00000000_00000000_00008020;
    apply_reset();
    c0_rw = 1'b0; c0_addr = 32'h0000_4010;
    c1_rw = 1'b0; c1_addr = 32'h0000_8020;
    c0_valid = 1'b1; c1_valid = 1'b1;
    wait_req(ok, n);
    total++;
    if (!ok || arb2mem_addr !== 32'h0000_4010) begin
      bad++;
      $display("FAIL tie_first: got ok=%0d addr=%h want 00004010", ok, arb2mem_addr);
    end
    mem_reply(1, lb);
    total++;
    if (c0_ready !== 1'b1 || c1_ready !== 1'b0 || c0_rdata !== lb) begin
      bad++;
      $display("FAIL tie_first_resp: got rdy=%b/%b data=%h want 1/0 %h", c0_ready, c1_ready, c0_rdata, lb);
    end
    c0_valid = 1'b0;
    wait_req(ok, n);
    total++;
    if (!ok || arb2mem_addr !== 32'h0000_8020) begin
      bad++;
      $display("FAIL tie_second: got ok=%0d addr=%h want 00008020", ok, arb2mem_addr);
    end
    mem_reply(0, lc);
    total++;
    if (c1_ready !== 1'b1 || c0_ready !== 1'b0 || c1_rdata !== lc || c0_rdata !== lb) begin
      bad++;
      $display("FAIL tie_second_resp: got rdy=%b/%b d1=%h want 0/1 %h", c0_ready, c1_ready, c1_rdata, lc);
    end
    c1_valid = 1'b0;
    exp_c1 = lc;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit ok; int n;
    logic who;
    logic [LW-1:0] d;
    both_rdy_cnt = 0;
    c0_rw = 1'b0; c0_addr = 32'h0000_0100;
    c1_rw = 1'b0; c1_addr = 32'h0000_0200;
    c0_valid = 1'b1; c1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok, n);
      who = (arb2mem_addr == 32'h0000_0200);
      total++;
      if (!ok || who !== 1'(i & 1)) begin
        bad++;
        $display("FAIL fair_order%0d: got ok=%0d who=%0d want %0d", i, ok, who, i & 1);
      end
      d = {96'h0, 32'(i + 32'hF00)};
      mem_reply(0, d);
      total++;
      if ((who ? c1_ready : c0_ready) !== 1'b1) begin
        bad++;
        $display("FAIL fair_ready%0d: got 0 want 1", i);
      end
      if (who) begin
        c1_valid = 1'b0;
        exp_c1 = d;
      end else begin
        c0_valid = 1'b0;
      end
      if (i == 3) begin
        c0_valid = 1'b0;
        c1_valid = 1'b0;
      end
      @(negedge clk);
      if (i != 3) begin
        if (who) c1_valid = 1'b1;
        else     c0_valid = 1'b1;
      end
    end
    @(negedge clk);
    total++;
    if (both_rdy_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fair_exclusive: got both=%0d busy=%b want 0 0", both_rdy_cnt, busy);
    end
  endtask

  task automatic test_write();
    bit ok; int n;
    logic [LW-1:0] wd = 128'h11111111_11111111_22222222_22222222;
    c1_rw = 1'b1; c1_addr = 32'h0000_C030; c1_wdata = wd; c1_valid = 1'b1;
    wait_req(ok, n);
    total++;
    if (!ok || arb2mem_rw !== 1'b1 || arb2mem_addr !== 32'h0000_C030 || arb2mem_data !== wd) begin
      bad++;
      $display("FAIL write_req: got rw=%b addr=%h data=%h want 1 0000c030 %h", arb2mem_rw, arb2mem_addr, arb2mem_data, wd);
    end
    mem_reply(1, 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0);
    total++;
    if (c1_ready !== 1'b1 || c1_rdata !== exp_c1) begin
      bad++;
      $display("FAIL write_resp: got rdy=%b data=%h want 1 %h", c1_ready, c1_rdata, exp_c1);
    end
    c1_valid = 1'b0; c1_rw = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; int n; int hi;
    c0_rw = 1'b0; c0_addr = 32'h0000_0500; c0_valid = 1'b1;
    wait_req(ok, n);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (!arb2mem_valid) break;
      hi++;
      @(negedge clk);
    end
    total++;
    if (!ok || hi != 8) begin
      bad++;
      $display("FAIL to_cycles: got ok=%0d busy_cycles=%0d want 8", ok, hi);
    end
    total++;
    if (c0_ready !== 1'b1 || c0_rdata !== '0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_resp: got rdy=%b data=%h err=%b want 1 0 1", c0_ready, c0_rdata, timeout_err);
    end
    c0_valid = 1'b0;
    @(negedge clk);
    c1_rw = 1'b0; c1_addr = 32'h0000_0600; c1_valid = 1'b1;
    wait_req(ok, n);
    mem_reply(0, 128'h5);
    c1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b1 || c1_rdata !== 128'h5) begin
      bad++;
      $display("FAIL to_sticky: got err=%b d1=%h want 1 5", timeout_err, c1_rdata);
    end
    apply_reset();
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_clear: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok; int n;
    c0_rw = 1'b0; c0_addr = 32'h0000_0600; c0_valid = 1'b1;
    wait_req(ok, n);
    @(negedge clk);
    rdy_cnt = 0;
    r = 1'b0;
    #1;
    total++;
    if ({arb2mem_valid, arb2mem_addr, c0_ready, c1_ready, c0_rdata, c1_rdata, busy} !== '0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b busy=%b want all zero", arb2mem_valid, busy);
    end
    c1_rw = 1'b0; c1_addr = 32'h0000_0700; c1_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (rdy_cnt != 0) begin
      bad++;
      $display("FAIL reset_no_ready: got %0d pulses want 0", rdy_cnt);
    end
    r = 1'b1;
    wait_req(ok, n);
    total++;
    if (!ok || arb2mem_addr !== 32'h0000_0600) begin
      bad++;
      $display("FAIL post_reset_first: got addr=%h want 00000600", arb2mem_addr);
    end
    mem_reply(0, 128'hA1);
    total++;
    if (c0_ready !== 1'b1 || c0_rdata !== 128'hA1) begin
      bad++;
      $display("FAIL post_reset_c0: got rdy=%b data=%h want 1 a1", c0_ready, c0_rdata);
    end
    c0_valid = 1'b0;
    wait_req(ok, n);
    total++;
    if (!ok || arb2mem_addr !== 32'h0000_0700) begin
      bad++;
      $display("FAIL post_reset_second: got addr=%h want 00000700", arb2mem_addr);
    end
    mem_reply(0, 128'hB2);
    total++;
    if (c1_ready !== 1'b1 || c1_rdata !== 128'hB2) begin
      bad++;
      $display("FAIL post_reset_c1: got rdy=%b data=%h want 1 b2", c1_ready, c1_rdata);
    end
    c1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    r = 1'b0;
    c0_valid = 1'b0; c0_rw = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_valid = 1'b0; c1_rw = 1'b0; c1_addr = '0; c1_wdata = '0;
    mem2arb_data = '0; mem2arb_ready = 1'b0;
    exp_c1 = '0;
    @(negedge clk);
    test_reset();
    r = 1'b1;
    @(negedge clk);
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_write();
    test_timeout();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cache-to-memory line port between two cache requesters: requester 0 is the instruction cache and requester 1 is the data cache.
- Sits between the two direct-mapped cache instances and the memory model. Each side uses the same valid/rw/addr/data/ready handshake as the existing cache2mem/mem2cache interface.
- Arbitrates round-robin, registers the winning request, and holds it on the memory port until memory responds. It then returns the line to the winner.
- Includes a response-timeout watchdog.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 128, cache line width.
- TIMEOUT, 255, maximum cycles to wait for mem2arb_ready in BUSY; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- r  in  1  reset, asynchronous, active-low.
- c0_valid  in  1  requester 0 request.
- c0_rw  in  1  1=write line, 0=read line.
- c0_addr  in  ADDR_W  line address.
- c0_wdata  in  LINE_W  write line.
- c0_rdata  out  LINE_W  returned line.
- c0_ready  out  1  one-cycle completion pulse.
- c1_valid, c1_rw, c1_addr, c1_wdata, c1_rdata, c1_ready  as c0, for requester 1.
- arb2mem_valid  out  1  memory request.
- arb2mem_rw  out  1  registered rw.
- arb2mem_addr  out  ADDR_W  registered address.
- arb2mem_data  out  LINE_W  registered write line.
- mem2arb_data  in  LINE_W  read line from memory.
- mem2arb_ready  in  1  memory completion.
- busy  out  1  high while state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (r low, asynchronous):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), grant=0, watchdog=0.
  - All outputs 0, including c*_rdata, arb2mem_*, and timeout_err.
  - Reset asserted mid-transaction aborts immediately. No ready pulse is produced, and memory sees arb2mem_valid fall asynchronously.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one cX_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant, at the same edge: latch cX_rw, cX_addr and cX_wdata into arb2mem_*; set arb2mem_valid=1; update last_grant; go to BUSY.
  - Latency from a sampled valid to arb2mem_valid is 1 cycle.
  - mem2arb_ready is ignored in IDLE.
- BUSY:
  - arb2mem_* are held stable; request inputs are ignored.
  - On an edge with mem2arb_ready=1: arb2mem_valid<=0; c[grant]_rdata<=mem2arb_data on reads, or is unchanged on writes; c[grant]_ready<=1; go to RESP.
  - Otherwise the watchdog increments.
  - When TIMEOUT!=0 and the watchdog equals TIMEOUT: arb2mem_valid<=0; timeout_err<=1; c[grant]_ready<=1 with c[grant]_rdata<=0; go to RESP.
- RESP:
  - c[grant]_ready is high for exactly one cycle, then the arbiter returns to IDLE and clears the watchdog.
  - The requester must deassert valid in the cycle it sees ready. A valid still high in the following IDLE cycle is treated as a new request.
  - The non-granted requester's valid stays pending and is served in the next IDLE cycle.
- Requester rules:
  - A requester must hold valid and its fields stable until its ready pulse.
  - Dropping valid early does not cancel an already-granted transaction.
- c*_rdata holds its last value between transactions. The ready outputs are mutually exclusive.
- timeout_err clears only on reset.
- Throughput: minimum 3 cycles per transaction (IDLE, BUSY, RESP) when memory responds in the first BUSY cycle.

Decomposition:
- Package cache_mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}.
  - Localparams for requester IDs (REQ_I=0, REQ_D=1).
  - Default ADDR_W/LINE_W.
- Sub-module rr_arb2: combinational two-input round-robin grant from (req[1:0], last_grant), plus a registered pointer update on grant enable. It is reused later by the write-buffer drain logic.

Test Plan:
- Single read: c0_valid=1, c0_addr=0x00000000, memory returns 0xDEADBEEF_..._01 with ready 2 cycles after arb2mem_valid -> arb2mem_addr=0x00000000, arb2mem_rw=0, and c0_ready pulses once with c0_rdata equal to that line.
- Simultaneous requests after reset: c0_addr=0x00004010, c1_addr=0x00008020 -> c0 is served first, c1 next; arb2mem_addr sequence is 0x00004010 then 0x00008020, and c1_ready follows c0_ready.
- Fairness: both requesters held continuously for 4 transactions -> grant order 0,1,0,1, with no cycle where both ready outputs are high.
- Write: c1_rw=1, c1_addr=0x0000C030, c1_wdata=0x1111...2222 -> arb2mem_rw=1 and arb2mem_data match; c1_rdata is unchanged after the c1_ready pulse.
- Timeout: TIMEOUT=8, memory never responds -> arb2mem_valid drops after 8 BUSY cycles, c0_ready pulses with c0_rdata=0, and timeout_err=1 stays high until r is low.
- Reset mid-BUSY: drive r low 2 cycles into BUSY -> all outputs are 0 immediately with no ready pulse; after release, a pending c1 and c0 pair is served with c0 first.
